// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_queue_pkg;

    // Default first fetch address after reset.
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    // Canonical NOP (addi x0,x0,0) the core injects for its own bubbles.
    localparam logic [31:0] IFQ_NOP = 32'h0000_0013;

    // One queued instruction, tagged with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    // Force a byte address onto a 32-bit word boundary.
    function automatic logic [31:0] ifq_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth, synchronous reset and flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_dat_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    // Accept handshakes; a full FIFO still takes a push when the head leaves.
    always_comb begin
        pop_ok  = pop_i && (count_q != '0);
        push_ok = push_i && ((count_q != DEPTH_C) || pop_ok);
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Pointer and occupancy state; flush empties the FIFO like a reset.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between a 1-cycle IROM and the IF stage.
// Latency: 2 cycles from request (or the cycle after a redirect) to fetch_valid_o.
// Backpressure: stops issuing once queued + in-flight entries reach DEPTH; no IROM stall.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        irom_req_o,
    output logic [13:0] irom_addr_o,
    input  logic [31:0] irom_rdata_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_instr_o,
    input  logic        fetch_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ;
    logic          issue;
    logic          resp_push;
    logic          head_pop;
    ifq_entry_t    push_ent;
    ifq_entry_t    head_ent;

    // Issue and queue control. Issue is suppressed during a redirect, so the
    // only response that can go stale is the one landing in the redirect
    // cycle itself; gating the push with redirect_i drops it. A pop in the
    // same cycle is deliberately not credited toward free space.
    always_comb begin
        occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue     = !rst && !redirect_i && (occ < DEPTH_W);
        resp_push = inflight_q && !redirect_i && !rst;
        head_pop  = fetch_valid_o && fetch_ready_i && !redirect_i;

        push_ent.pc    = inflight_pc_q;
        push_ent.instr = irom_rdata_i;

        fpc_d         = fpc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            fpc_d = ifq_align(redirect_pc_i);
        end else if (issue) begin
            fpc_d         = fpc_q + 32'd4;
            inflight_pc_d = fpc_q;
        end
    end

    // Fetch PC and in-flight tracking; reset discards any outstanding response.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= ifq_align(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ifq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect_i),
        .push_i     (resp_push),
        .push_dat_i (push_ent),
        .pop_i      (head_pop),
        .head_dat_o (head_ent),
        .count_o    (fifo_count)
    );

    assign irom_req_o    = issue;
    assign irom_addr_o   = fpc_q[15:2];
    assign fetch_valid_o = !rst && (fifo_count != '0);
    assign fetch_pc_o    = fetch_valid_o ? head_ent.pc    : 32'h0;
    assign fetch_instr_o = fetch_valid_o ? head_ent.instr : 32'h0;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 irom_req_o  output  1  fetch request issued this cycle.
REQ-006 irom_addr_o  output  14  IROM word address, equal to the fetch PC bits [15:2].
REQ-007 irom_rdata_i  input  32  IROM read data, valid the cycle after the request.
REQ-008 fetch_valid_o  output  1  queue head holds a valid instruction.
REQ-009 fetch_pc_o  output  32  PC of the head instruction.
REQ-010 fetch_instr_o  output  32  head instruction word.
REQ-011 fetch_ready_i  input  1  IF stage accepts the head; low while the core stalls.
REQ-012 redirect_i  input  1  taken branch/jump from EX; discard all queued and in-flight fetches.
REQ-013 redirect_pc_i  input  32  new fetch address.

Function
REQ-014 The block SHALL keep a fetch PC fpc that advances by 4 on each issued request and wraps modulo 2^32.
REQ-015 Issue: irom_req_o SHALL be 1 when not in reset, redirect_i=0, and (count + inflight) < DEPTH.
- inflight is 0 or 1.
- A pop in the same cycle is not credited.
REQ-016 IROM contract: the response SHALL arrive exactly one cycle after the request, with no backpressure.
- A non-stale response is written at the tail with tag pc = address issued.
REQ-017 Pop: a head entry SHALL leave when fetch_valid_o=1 and fetch_ready_i=1.
- Push and pop in the same cycle SHALL be legal at any count, including full and empty.
- Count is unchanged when both occur.
REQ-018 While fetch_valid_o=1 and fetch_ready_i=0, fetch_pc_o and fetch_instr_o SHALL hold stable.
REQ-019 fetch_valid_o SHALL equal (count != 0); there is no bypass from irom_rdata_i to the outputs.
REQ-020 Redirect: with redirect_i=1, the block SHALL at the next edge:
- set count to 0;
- mark any in-flight response stale, so the response arriving the following cycle is dropped;
- load fpc with {redirect_pc_i[31:2], 2'b00}.
REQ-021 Redirect SHALL take priority over a simultaneous push, pop or issue in the same cycle.
- The first request to the new target issues the cycle after redirect_i.
REQ-022 Back-to-back redirects SHALL each restart fetch; only the last target is fetched.
REQ-023 Latency from a request, or from the cycle following a redirect, to fetch_valid_o=1 SHALL be 2 cycles.
REQ-024 Steady state with fetch_ready_i held high and DEPTH≥2 SHALL deliver one instruction per cycle.
REQ-025 Order: instructions SHALL be delivered in strictly increasing fetch order with no duplication or loss.
REQ-026 fetch_pc_o[1:0] SHALL always be 2'b00.

Reset
REQ-027 While rst=1 the following outputs SHALL be held:
- irom_req_o=0, fetch_valid_o=0, fetch_pc_o=0, fetch_instr_o=0;
- count=0, inflight=0, fpc=RESET_PC.
REQ-028 The first request (address RESET_PC[15:2]) SHALL issue in the first cycle with rst=0.
REQ-029 Reset asserted mid-operation SHALL abort all activity.
- Any response arriving the cycle after reset asserts SHALL be dropped.

Structure
REQ-030 The shared package SHALL hold:
- the queue entry typedef {pc[31:0], instr[31:0]};
- the NOP constant 32'h0000_0013 for core-side bubbles;
- the RESET_PC default.
REQ-031 Storage SHALL be one sub-module, sync_fifo, parameterised by width and depth, with synchronous flush.
- ifetch_queue holds fpc, inflight/stale tracking and issue logic.

Verification
REQ-032 Reset release, fetch_ready_i=1, IROM returns addr*4 as data:
- irom_req_o cycle 1 with addr 0;
- fetch_valid_o cycle 3, pc=0;
- then pc 4, 8, 12 on consecutive cycles.
REQ-033 fetch_ready_i=0 for 10 cycles:
- requests stop with count=4 (DEPTH=4);
- head pc and instr are stable;
- on release, 4 buffered entries drain with no gap.
REQ-034 redirect_i=1, redirect_pc_i=32'h0000_0103, while a request is in flight and the queue is full:
- that in-flight response is dropped;
- next irom_addr_o=14'h0040;
- first valid pc=32'h0000_0100, 2 cycles after the request.
REQ-035 redirect_i in the same cycle as a pop and a push: count becomes 0 and no stale entry ever appears at the outputs.
REQ-036 fpc=32'hFFFF_FFFC, queue free: the next request address bits come from 32'h0000_0000, delivered pcs are FFFF_FFFC then 0000_0000.
REQ-037 rst asserted for 1 cycle mid-stream with a request in flight: that response is dropped, and the next delivered pc is RESET_PC.
